align_shift_pipe: RTL

Parametrised, pipelined barrel shifter for floating-point mantissa alignment and normalisation. It generalises the fixed 24-bit, 5-level combinational right shifter: width and shift range are parameters, it adds arithmetic-right and logical-left modes, and it produces guard/round/sticky bits. Pipeline registers sit between groups of shift levels, and a valid/ready handshake with backpressure controls flow. It sits between exponent-difference logic and the mantissa adder, and reuses in the normaliser (left mode).

---
 rtl/align_shift_pipe_if.sv | 28 ++
 rtl/align_shift_pipe.sv | 111 +++++++++++
 2 files changed

// File: rtl/align_shift_pipe_if.sv
// Handshake and data bundle for align_shift_pipe.
// The master side is the producer/consumer pair; the slave side is the shifter.
interface align_shift_pipe_if #(
    parameter int WIDTH = 24,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_guard;
    logic             out_round;
    logic             out_sticky;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_guard, out_round, out_sticky
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_guard, out_round, out_sticky
    );
endinterface

// File: rtl/align_shift_pipe.sv
// Pipelined barrel shifter for mantissa alignment/normalisation with guard,
// round and sticky outputs; a global stall holds every stage under backpressure.
module align_shift_pipe #(
    parameter int WIDTH     = 24,
    parameter int SHW       = 5,
    parameter int REG_EVERY = 2
) (
    input  logic               clk,
    input  logic               rst,
    align_shift_pipe_if.slave  bus
);
    localparam int DW = WIDTH + 2;

    // Element k is the beat entering level k; element SHW is the final register.
    logic [DW-1:0]  lv_d [SHW+1];
    logic           lv_s [SHW+1];
    logic           lv_v [SHW+1];
    logic [SHW-1:0] lv_a [SHW];
    logic [1:0]     lv_m [SHW];

    logic en;

    assign en           = !lv_v[SHW] || bus.out_ready;
    assign bus.in_ready = en;

    assign lv_d[0] = {bus.in_data, 2'b00};
    assign lv_s[0] = 1'b0;
    assign lv_v[0] = bus.in_valid;
    assign lv_a[0] = bus.in_amt;
    assign lv_m[0] = bus.in_mode;

    for (genvar l = 0; l < SHW; l++) begin : g_lvl
        localparam int SH  = 1 << (SHW - 1 - l);
        // Shifting by DW or more already yields all-fill data, so clamp.
        localparam int SHC = (SH > DW) ? DW : SH;
        localparam logic [DW-1:0] LMASK = {DW{1'b1}} >> (DW - SHC);
        localparam bit REG = (((l + 1) % REG_EVERY) == 0) || (l == SHW - 1);

        logic          fill;
        logic [DW-1:0] d_c;
        logic          s_c;

        assign fill = (lv_m[l] == 2'b01) && lv_d[l][DW-1];

        always_comb begin
            d_c = lv_d[l];
            s_c = lv_s[l];
            if (lv_a[l][SHW-1-l]) begin
                if (lv_m[l] == 2'b10) begin
                    d_c = lv_d[l] << SHC;
                end else begin
                    d_c = DW'({{DW{fill}}, lv_d[l]} >> SHC);
                    s_c = lv_s[l] | (|(lv_d[l] & LMASK));
                end
            end
        end

        if (REG) begin : g_reg
            logic          v_q;
            logic [DW-1:0] d_q;
            logic          s_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                    s_q <= 1'b0;
                end else if (en) begin
                    v_q <= lv_v[l];
                    d_q <= d_c;
                    s_q <= s_c;
                end
            end

            assign lv_v[l+1] = v_q;
            assign lv_d[l+1] = d_q;
            assign lv_s[l+1] = s_q;

            // The final stage has no further levels, so it drops amount and mode.
            if (l < SHW - 1) begin : g_am
                logic [SHW-1:0] a_q;
                logic [1:0]     m_q;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        m_q <= '0;
                    end else if (en) begin
                        a_q <= lv_a[l];
                        m_q <= lv_m[l];
                    end
                end

                assign lv_a[l+1] = a_q;
                assign lv_m[l+1] = m_q;
            end
        end else begin : g_comb
            assign lv_v[l+1] = lv_v[l];
            assign lv_d[l+1] = d_c;
            assign lv_s[l+1] = s_c;
            assign lv_a[l+1] = lv_a[l];
            assign lv_m[l+1] = lv_m[l];
        end
    end

    assign bus.out_valid  = lv_v[SHW];
    assign bus.out_data   = lv_d[SHW][DW-1:2];
    assign bus.out_guard  = lv_d[SHW][1];
    assign bus.out_round  = lv_d[SHW][0];
    assign bus.out_sticky = lv_s[SHW];
endmodule
